// File: rtl/seq_mul_24.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_24
// Purpose  : Sequential radix-2 shift-and-add multiplier. Takes two WIDTH-bit
//            operands (unsigned or two's complement) and produces a 2*WIDTH-bit
//            product after WIDTH iterations. Uses a start/busy/done handshake,
//            and the result is held until the next operation completes.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            start      - request a new multiply (honoured in IDLE or DONE)
//            signed_op  - 1: two's complement operands, 0: unsigned
//            a, b       - multiplicand / multiplier, sampled with start
//            busy       - high during the WIDTH RUN cycles
//            done       - one-cycle pulse, product valid from this cycle on
//            product    - 2*WIDTH-bit result
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_24 #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    // The accumulator's low half is preloaded with |b|: each iteration
    // consumes the multiplier bit at position 0 while the partial product
    // grows downward from the top, so after WIDTH shifts it holds the full
    // unsigned product of the magnitudes.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mag_a;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Magnitudes: negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is still
    // correct when read as an unsigned WIDTH-bit value.
    assign w_mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

    // Add stage keeps its carry (WIDTH+1 bits); it becomes the new MSB after
    // the right shift.
    assign w_addend   = r_acc[0] ? r_mag_a : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    assign w_last  = (r_cnt == c_cnt_one);
    assign product = r_product;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mag_a   <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_mag_a <= w_mag_a;
            r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt   <= c_cnt_init;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - c_cnt_one;
            if (w_last) begin
                r_product <= r_neg ? -w_acc_next : w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_mul_24.md
Name: seq_mul_24

Overview:
- Sequential radix-2 shift-and-add multiplier: WIDTH x WIDTH operands give a 2*WIDTH product.
- It is the inverse arithmetic companion to the team's combinational 24-bit restoring divider. The ALU datapath uses it for MUL, where a single-cycle array multiplier would break timing.
- It has a start/busy/done handshake, supports unsigned and two's-complement signed operands, and holds its result until the next operation.

Parameters:
- WIDTH, 24, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a new multiply; sampled only in IDLE or DONE.
- signed_op  in  1  1 = treat a and b as two's complement; 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product is valid from this cycle on.
- product  out  2*WIDTH  result; held stable until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - state = IDLE; busy = 0; done = 0; product = 0; internal registers = 0.
  - rst asserted mid-RUN aborts the operation at that edge. No done is produced, and product reads 0 afterwards.
- States: IDLE, RUN, DONE.
- Accept (edge 0): start = 1 while in IDLE or DONE.
  - Latch mag_a = |a| and mag_b = |b|. In signed mode the magnitude is the two's-complement negation when the MSB is 1; in unsigned mode the operands are latched as-is.
  - Latch neg = signed_op & (a[MSB] ^ b[MSB]).
  - Clear the accumulator (2*WIDTH bits) and load the bit counter with WIDTH.
  - Go to RUN.
- start outside IDLE/DONE (i.e. in RUN) is ignored; no queuing.
- RUN iterations: edges 1..WIDTH, one per edge.
  - If mag_b[0] = 1, add mag_a to the upper WIDTH+1 bits of the accumulator.
  - Then shift the accumulator right by one, and shift mag_b right by one.
  - Decrement the counter.
- On edge WIDTH (counter reaches 0):
  - product <= neg ? -acc : acc, computed in 2*WIDTH bits.
  - Go to DONE.
- DONE lasts one cycle: done = 1, busy = 0.
  - Next edge: go to IDLE, or straight to RUN if start = 1 (back-to-back accepted).
  - done falls unless the new operation itself completes; it cannot complete in one cycle.
- Latency: start sampled at edge 0; done high in the cycle following edge WIDTH (24 cycles for WIDTH = 24). Throughput is one result per WIDTH+1 cycles.
- busy = 1 exactly during RUN cycles, WIDTH cycles per operation.
- product keeps its previous value through RUN and updates only on the final RUN edge.
- Arithmetic:
  - Unsigned: exact a*b, no overflow possible.
  - Signed: exact; -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) fits positively.
  - The magnitude of -2^(WIDTH-1) is representable in WIDTH unsigned bits.
  - The add stage carry must be kept (WIDTH+1 bits) before shifting.
- Operand changes on a/b/signed_op after the accept edge have no effect.
- Zero operand: the full WIDTH cycles still run (no early termination), keeping latency fixed.

Test Plan:
- Unsigned basic: a = 3, b = 5, signed_op = 0, start pulse -> busy high 24 cycles; done pulses once at cycle 24 after start; product = 0x00000000000F.
- Unsigned max: a = b = 0xFFFFFF -> product = 0xFFFFFE000001; repeat with a = 0 -> product = 0, same latency.
- Signed mixed: a = 0xFFFFFD (-3), b = 7, signed_op = 1 -> product = 0xFFFFFFFFFFEB (-21). Then a = b = 0x800000 -> product = 0x400000000000.
- Handshake: start held high through RUN with changing a/b -> only the first operands are used. Start high in the DONE cycle with a = 2, b = 9 -> new RUN begins with no IDLE cycle; next done shows product = 18. Old product is held until that point.
- Reset mid-operation: assert rst at RUN cycle 10 -> next cycle busy = 0, done = 0, product = 0, state IDLE. A subsequent start with a = 6, b = 7 gives 42 with normal latency.
- Random regression: 10k random a/b/signed_op against a reference model with back-to-back starts. Check that done occurs exactly WIDTH+1 cycles apart and that busy/done are never high together.
